// File: rtl/vlc_tx_serializer_pkg.sv
// Shared types and constants for the VLC transmit serializer.
package vlc_tx_pkg;

  // Serializer control states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4
  } state_e;

  localparam int DATA_W     = 32;
  localparam int PREAMBLE_W = 8;
  localparam int FRAME_BITS = PREAMBLE_W + DATA_W;  // 40

  // Number of high cycles per 16-cycle PWM period for each dim code
  localparam logic [4:0] DIM_THR_OFF  = 5'd0;
  localparam logic [4:0] DIM_THR_25   = 5'd4;
  localparam logic [4:0] DIM_THR_50   = 5'd8;
  localparam logic [4:0] DIM_THR_FULL = 5'd16;

  // Map the 2-bit dim field onto its duty threshold
  function automatic logic [4:0] dim_threshold(input logic [1:0] dim);
    logic [4:0] thr;
    case (dim)
      2'b00:   thr = DIM_THR_OFF;
      2'b01:   thr = DIM_THR_25;
      2'b10:   thr = DIM_THR_50;
      2'b11:   thr = DIM_THR_FULL;
      default: thr = DIM_THR_OFF;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/vlc_tx_serializer_if.sv
// TX FIFO read port between the AXI-Lite wrapper FIFO and the serializer.
interface vlc_tx_serializer_if;
  import vlc_tx_pkg::*;

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;

  // Serializer side: pops words
  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  // FIFO side: supplies words
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);

endinterface

// File: rtl/vlc_tx_serializer_dim_pwm.sv
// Idle-brightness PWM: free-running 4-bit phase compared with the dim duty.
module vlc_dim_pwm
  import vlc_tx_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] dim,
  output logic       led_idle
);

  logic [3:0] p_r;

  // Free-running PWM phase counter, runs in every serializer state
  always_ff @(posedge clk) begin
    if (srst) begin
      p_r <= 4'd0;
    end else begin
      p_r <= p_r + 4'd1;
    end
  end

  // dim is used directly so a new level shows up on the next registered led
  assign led_idle = ({1'b0, p_r} < dim_threshold(dim));

endmodule

// File: rtl/vlc_tx_serializer.sv
// Pops 32-bit words from the TX FIFO, prefixes the preamble and drives them
// Manchester-encoded (MSB first) onto the LED; PWM dimming between frames.
module vlc_tx_serializer
  import vlc_tx_pkg::*;
#(
  parameter int                    CLK_DIV  = 100,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE = 8'hAB,
  parameter int                    GAP_BITS = 2
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic                reset,
  vlc_tx_serializer_if.master fifo,
  input  logic [1:0]          dim,
  output logic                led,
  output logic                busy,
  output logic                word_done
);

  localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
  localparam int CW      = $clog2(CLK_DIV);
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CW-1:0] CHIP_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [5:0]    BIT_LAST  = 6'(FRAME_BITS - 1);

  logic                  srst_s;
  state_e                state_r, state_s;
  logic [FRAME_BITS-1:0] shift_r, shift_s;
  logic [5:0]            bit_idx_r, bit_idx_s;
  logic [CW-1:0]         chip_cnt_r, chip_cnt_s;
  logic                  half_r, half_s;        // 0: first chip of bit, 1: second
  logic [GW-1:0]         gap_cnt_r, gap_cnt_s;
  logic                  chip_end_s, frame_end_s;
  logic                  led_idle_s;
  logic                  led_s, busy_s, word_done_s, rd_en_s;
  logic                  led_r, busy_r, word_done_r, rd_en_r;

  // Either reset source clears everything on the next edge
  assign srst_s = ~s_axi_aresetn | reset;

  vlc_dim_pwm u_dim_pwm (
    .clk      (s_axi_aclk),
    .srst     (srst_s),
    .dim      (dim),
    .led_idle (led_idle_s)
  );

  // State and datapath registers
  always_ff @(posedge s_axi_aclk) begin
    if (srst_s) begin
      state_r    <= IDLE;
      shift_r    <= {FRAME_BITS{1'b0}};
      bit_idx_r  <= 6'd0;
      chip_cnt_r <= {CW{1'b0}};
      half_r     <= 1'b0;
      gap_cnt_r  <= {GW{1'b0}};
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      chip_cnt_r <= chip_cnt_s;
      half_r     <= half_s;
      gap_cnt_r  <= gap_cnt_s;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_idx_s   = bit_idx_r;
    chip_cnt_s  = chip_cnt_r;
    half_s      = half_r;
    gap_cnt_s   = gap_cnt_r;
    chip_end_s  = (chip_cnt_r == CHIP_LAST);
    frame_end_s = chip_end_s && half_r && (bit_idx_r == BIT_LAST);
    case (state_r)
      // The pop strobe is already on the port in this cycle; leave once it fired
      IDLE: begin
        if (rd_en_r) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: state_s = LOAD;
      LOAD: begin
        shift_s    = {PREAMBLE, fifo.fifo_dout};
        bit_idx_s  = 6'd0;
        chip_cnt_s = {CW{1'b0}};
        half_s     = 1'b0;
        state_s    = SEND;
      end
      SEND: begin
        if (chip_end_s) begin
          chip_cnt_s = {CW{1'b0}};
          if (half_r) begin
            half_s    = 1'b0;
            bit_idx_s = bit_idx_r + 6'd1;
            shift_s   = {shift_r[FRAME_BITS-2:0], 1'b0};
          end else begin
            half_s = 1'b1;
          end
        end else begin
          chip_cnt_s = chip_cnt_r + CW'(1'b1);
        end
        if (frame_end_s) begin
          state_s   = GAP;
          bit_idx_s = 6'd0;
          gap_cnt_s = {GW{1'b0}};
        end else begin
          state_s = SEND;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s   = IDLE;
          gap_cnt_s = {GW{1'b0}};
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1'b1);
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode from next-cycle values so the registered outputs line up with the state
  always_comb begin
    led_s = led_idle_s;
    if (state_s == SEND) begin
      // data 1: low then high; data 0: high then low
      led_s = half_s ? shift_s[FRAME_BITS-1] : ~shift_s[FRAME_BITS-1];
    end else begin
      led_s = led_idle_s;
    end
    busy_s      = (state_s != IDLE);
    word_done_s = (state_r == SEND) && frame_end_s;
    // Only this block pops the FIFO, so a non-empty flag seen now still holds next cycle
    rd_en_s     = (state_s == IDLE) && !fifo.fifo_empty;
  end

  // Registered outputs
  always_ff @(posedge s_axi_aclk) begin
    if (srst_s) begin
      led_r       <= 1'b0;
      busy_r      <= 1'b0;
      word_done_r <= 1'b0;
      rd_en_r     <= 1'b0;
    end else begin
      led_r       <= led_s;
      busy_r      <= busy_s;
      word_done_r <= word_done_s;
      rd_en_r     <= rd_en_s;
    end
  end

  assign led             = led_r;
  assign busy            = busy_r;
  assign word_done       = word_done_r;
  assign fifo.fifo_rd_en = rd_en_r;

endmodule

// File: tb/tb_vlc_tx_serializer.sv
// Self-checking bench for vlc_tx_serializer with a queue-based FIFO model
// and a frame-level Manchester reference.
module tb_vlc_tx_serializer;

  localparam int         CLK_DIV   = 4;
  localparam int         GAP_BITS  = 2;
  localparam logic [7:0] PRE       = 8'hAB;
  localparam int         FRAME_CYC = 40 * 2 * CLK_DIV;        // 320
  localparam int         GAP_CYC   = GAP_BITS * 2 * CLK_DIV;  // 16
  localparam int         LAST_K    = 3 + FRAME_CYC + GAP_CYC;  // first IDLE cycle after the frame

  logic       clk;
  logic       aresetn;
  logic       soft_rst;
  logic [1:0] dim;
  logic       led;
  logic       busy;
  logic       word_done;

  int total = 0;
  int bad   = 0;
  int bad_pops = 0;
  logic [31:0] q[$];

  vlc_tx_serializer_if fifo_if();

  vlc_tx_serializer #(
    .CLK_DIV  (CLK_DIV),
    .PREAMBLE (PRE),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .reset         (soft_rst),
    .fifo          (fifo_if),
    .dim           (dim),
    .led           (led),
    .busy          (busy),
    .word_done     (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard (non-FWFT) FIFO: data valid the cycle after a pop
  always @(posedge clk) begin
    if (fifo_if.fifo_rd_en === 1'b1) begin
      if (fifo_if.fifo_empty !== 1'b0 || q.size() == 0) bad_pops++;
      else fifo_if.fifo_dout <= q.pop_front();
    end
    fifo_if.fifo_empty <= (q.size() == 0);
  end

  function automatic int exp_high(input logic [1:0] d);
    case (d)
      2'd0:    return 0;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 16;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a pop of word w and check the whole frame plus gap against the model.
  // dim is dim_a until cycle sw_k after the pop (0 = never), then dim_b.
  task automatic observe_frame(input logic [31:0] w, input logic [1:0] dim_a,
                               input logic [1:0] dim_b, input int sw_k, input logic exp_next);
    logic [39:0] frame, got;
    logic        bit_v, exp_led;
    logic [1:0]  gap_dim;
    int waited, chip_err, wd_cnt, wd_at, busy_cnt, gap_hi, rd_extra, s, chip;
    frame = {PRE, w};
    got = 40'd0;
    dim = dim_a;
    gap_dim = (sw_k >= 1 && sw_k < 3 + FRAME_CYC) ? dim_b : dim_a;
    waited = 0;
    while (fifo_if.fifo_rd_en !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    total++;
    if (fifo_if.fifo_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL pop_wait: rd_en=%b after %0d cycles, required 1", fifo_if.fifo_rd_en, waited);
    end else begin
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_at_pop: busy=%b required 0", busy);
      end
      chip_err = 0; wd_cnt = 0; wd_at = -1; busy_cnt = 0; gap_hi = 0; rd_extra = 0;
      for (int k = 1; k <= LAST_K; k++) begin
        tick();
        if (k == sw_k) dim = dim_b;
        if (busy === 1'b1) busy_cnt++;
        if (word_done === 1'b1) begin
          wd_cnt++;
          wd_at = k;
        end
        if (k < LAST_K && fifo_if.fifo_rd_en !== 1'b0) rd_extra++;
        if (k >= 3 && k < 3 + FRAME_CYC) begin
          s = k - 3;
          chip = s / CLK_DIV;
          bit_v = frame[39 - chip / 2];
          exp_led = (chip % 2 == 0) ? ~bit_v : bit_v;
          if (led !== exp_led) chip_err++;
          if (s % (2 * CLK_DIV) == (3 * CLK_DIV) / 2) got[39 - chip / 2] = led;
        end
        if (k >= 3 + FRAME_CYC && k < LAST_K && led === 1'b1) gap_hi++;
      end
      total++;
      if (chip_err != 0) begin
        bad++;
        $display("FAIL manchester_wave: %0d wrong chip cycles for word %08h, required 0", chip_err, w);
      end
      total++;
      if (got !== frame) begin
        bad++;
        $display("FAIL decoded_frame: got %010h required %010h", got, frame);
      end
      total++;
      if (wd_cnt != 1 || wd_at != 3 + FRAME_CYC) begin
        bad++;
        $display("FAIL word_done: %0d pulses last at %0d, required 1 at %0d", wd_cnt, wd_at, 3 + FRAME_CYC);
      end
      total++;
      if (busy_cnt != 2 + FRAME_CYC + GAP_CYC) begin
        bad++;
        $display("FAIL busy_len: %0d cycles required %0d", busy_cnt, 2 + FRAME_CYC + GAP_CYC);
      end
      total++;
      if (gap_hi != exp_high(gap_dim)) begin
        bad++;
        $display("FAIL gap_pwm: %0d high cycles in gap, required %0d (dim=%0d)", gap_hi, exp_high(gap_dim), gap_dim);
      end
      total++;
      if (rd_extra != 0) begin
        bad++;
        $display("FAIL extra_pop: %0d rd_en cycles inside frame, required 0", rd_extra);
      end
      total++;
      if (fifo_if.fifo_rd_en !== exp_next) begin
        bad++;
        $display("FAIL next_pop: rd_en=%b on first idle cycle, required %b", fifo_if.fifo_rd_en, exp_next);
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    soft_rst = 1'b0;
    dim = 2'd0;
    repeat (3) tick();
    total++;
    if ({led, busy, word_done, fifo_if.fifo_rd_en} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: led/busy/wd/rd=%b required 0000", {led, busy, word_done, fifo_if.fifo_rd_en});
    end
    aresetn = 1'b1;
    repeat (4) tick();
    total++;
    if ({busy, fifo_if.fifo_rd_en} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: busy/rd=%b required 00", {busy, fifo_if.fifo_rd_en});
    end
  endtask

  task automatic test_pwm();
    logic [1:0] dims[4];
    int cnt, rd_seen;
    dims[0] = 2'd2; dims[1] = 2'd0; dims[2] = 2'd1; dims[3] = 2'd3;
    for (int d = 0; d < 4; d++) begin
      dim = dims[d];
      rd_seen = 0;
      tick();
      for (int blk = 0; blk < 31; blk++) begin
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
          tick();
          if (led === 1'b1) cnt++;
          if (fifo_if.fifo_rd_en !== 1'b0) rd_seen++;
        end
        total++;
        if (cnt != exp_high(dims[d])) begin
          bad++;
          $display("FAIL pwm_duty: dim=%0d block %0d high=%0d required %0d", dims[d], blk, cnt, exp_high(dims[d]));
        end
      end
      total++;
      if (rd_seen != 0) begin
        bad++;
        $display("FAIL pop_when_empty: dim=%0d rd_en seen %0d cycles, required 0", dims[d], rd_seen);
      end
    end
  endtask

  task automatic test_frames();
    logic [31:0] w;
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 32'hA500_0001 : $urandom;
      q.push_back(w);
      if (n == 0) observe_frame(w, 2'd0, 2'd0, 0, 1'b0);
      else observe_frame(w, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                         $urandom_range(5, 300), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    q.push_back(32'hFFFF_FFFF);
    q.push_back(32'h0000_0000);
    observe_frame(32'hFFFF_FFFF, 2'd1, 2'd1, 0, 1'b1);
    observe_frame(32'h0000_0000, 2'd2, 2'd2, 0, 1'b0);
  endtask

  task automatic test_dim_toggle();
    logic [31:0] w;
    w = $urandom;
    q.push_back(w);
    observe_frame(w, 2'd0, 2'd3, 100, 1'b0);
    dim = 2'd0;
    repeat (2) tick();
  endtask

  // mode 0: hard reset, 1: soft reset, 2: both together
  task automatic test_reset_mid(input int mode);
    logic [31:0] wa, wb;
    int waited;
    wa = $urandom;
    wa[19] = 1'b0;   // bit 20 of the frame is 0, so its first chip would be high
    wb = $urandom;
    dim = 2'd0;
    q.push_back(wa);
    q.push_back(wb);
    waited = 0;
    while (fifo_if.fifo_rd_en !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    repeat (3 + 20 * 2 * CLK_DIV + 2) tick();
    if (mode != 1) aresetn = 1'b0;
    if (mode != 0) soft_rst = 1'b1;
    tick();
    aresetn = 1'b1;
    soft_rst = 1'b0;
    total++;
    if ({led, busy, word_done, fifo_if.fifo_rd_en} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_%0d: led/busy/wd/rd=%b required 0000", mode, {led, busy, word_done, fifo_if.fifo_rd_en});
    end
    observe_frame(wb, 2'd0, 2'd0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_frames();
    test_back_to_back();
    test_dim_toggle();
    test_reset_mid(0);
    test_reset_mid(1);
    test_reset_mid(2);
    total++;
    if (bad_pops != 0) begin
      bad++;
      $display("FAIL fifo_protocol: %0d pops while empty, required 0", bad_pops);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
